sram_serial_host: RTL and testbench
===================================

Name:
sram_serial_host

Overview:
Host-side driver for the serial-write / parallel-read SRAM macro port (serial_in, shift, w_en, r_en, addr, data_valid, data_out). It accepts word-level write and read requests over a valid/ready interface. Writes are serialised onto serial_in under shift, then committed with a w_en pulse. Reads issue an r_en pulse and return the captured data_out, with a timeout. It sits between the system/bus side and the SRAM top, and SRAM-side ports connect by name to the macro.

Parameters:
ROWS, 16, number of SRAM words; address width is $clog2(ROWS)
COLS, 8, word width in bits; equals the number of shift cycles per write
TIMEOUT, 16, maximum cycles to wait for data_valid after r_en before aborting a read

Ports:
clk  input  1  system clock, all logic rising-edge
arst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_write  input  1  1=write, 0=read; sampled on handshake
req_addr  input  $clog2(ROWS)  target word; sampled on handshake
req_wdata  input  COLS  write data; sampled on handshake
wr_done  output  1  one-cycle pulse: write committed
rsp_valid  output  1  one-cycle pulse: read response
rsp_rdata  output  COLS  read data, held until next rsp_valid
rsp_timeout  output  1  qualifies rsp_valid: read aborted, rsp_rdata=0
serial_in  output  1  serial write bit to SRAM
shift  output  1  SRAM shift-register enable
w_en  output  1  SRAM write strobe
r_en  output  1  SRAM read strobe
addr  output  $clog2(ROWS)  SRAM address
data_valid  input  1  SRAM read data valid
data_out  input  COLS  SRAM read data

Behaviour:
- Reset (arst_n=0, asynchronous): state=IDLE. All outputs are 0 except req_ready=1. The shift register, counters and rsp_rdata clear.
- Handshake: a request is accepted when req_valid and req_ready are both 1 on a rising edge. req_ready=1 only in IDLE, so there is one outstanding request at a time. addr, data and direction latch on acceptance.
- FSM states: IDLE, SHIFT, COMMIT, READ, WAIT.
- IDLE:
  - Accepted write -> SHIFT, bit counter=0.
  - Accepted read -> READ.
- SHIFT, lasting exactly COLS cycles:
  - shift=1.
  - serial_in = latched word, MSB first (bit COLS-1 on the first cycle, bit 0 on the last).
  - After the COLS-th cycle -> COMMIT.
- COMMIT, 1 cycle:
  - w_en=1, addr=latched address, shift=0.
  - wr_done pulses in the same cycle.
  - -> IDLE.
  - Write latency: handshake edge to w_en = COLS+1 cycles; req_ready returns COLS+2 cycles after the handshake.
- READ, 1 cycle:
  - r_en=1, addr=latched address.
  - The timeout counter clears.
  - -> WAIT.
- WAIT:
  - addr stays held; r_en=0.
  - On the first cycle data_valid=1: rsp_rdata<=data_out and rsp_valid pulses next cycle with rsp_timeout=0; -> IDLE.
  - If TIMEOUT cycles elapse with no data_valid: rsp_valid=1, rsp_timeout=1, rsp_rdata=0; -> IDLE.
  - data_valid and the final timeout cycle coinciding: the data wins and no timeout is reported.
- addr holds the last latched value in IDLE. serial_in=0 whenever shift=0.
- data_valid in any state other than WAIT is ignored and does not change rsp_rdata.
- Outputs are registered; there is no combinational path from req_* or data_* to SRAM-side outputs.
- req_valid with req_ready=0: the request is held by the requester and not consumed. req_* may change freely while not handshaking.
- Reset mid-operation: an immediate return to the reset state.
  - A partial SHIFT produces no w_en.
  - A pending read produces no rsp_valid.
- Back-to-back requests: the next request is accepted on the first IDLE cycle, with no extra bubble.

Test Plan:
- Reset: hold arst_n=0 for 2 cycles, deassert -> req_ready=1; shift, w_en, r_en, wr_done and rsp_valid are 0; addr=0.
- Single write (COLS=8): addr=5, wdata=8'hA5.
  - serial_in=1,0,1,0,0,1,0,1 over 8 shift=1 cycles.
  - Then w_en=1 with addr=5 and wr_done=1, 9 cycles after the handshake.
  - req_ready=1 again at cycle 10.
- Read: addr=5; a model returns data_valid with data_out=8'hA5 3 cycles after r_en -> r_en is a 1-cycle pulse with addr=5; rsp_valid=1 with rsp_rdata=8'hA5 and rsp_timeout=0.
- Timeout: read addr=3 with data_valid never asserted -> rsp_valid=1, rsp_timeout=1, rsp_rdata=0, exactly TIMEOUT(16) cycles after leaving READ.
- Full sweep against the SRAM top: write addr k with data ~k for k=0..15, then read all 16 -> every rsp_rdata equals ~k[7:0], no timeouts.
- Reset mid-shift: arst_n=0 at the 4th shift cycle of a write -> no w_en or wr_done; after release req_ready=1, and a subsequent read of that address returns its prior contents.

Source files
------------

// File: rtl/sram_serial_host.sv
// Host-side driver for a serial-write / parallel-read SRAM macro port.
// Word requests arrive over valid/ready; writes are shifted MSB first and then committed, reads wait for data_valid with a timeout.
module sram_serial_host #(
    parameter int ROWS    = 16,
    parameter int COLS    = 8,
    parameter int TIMEOUT = 16,
    localparam int AW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [AW-1:0]   req_addr,
    input  logic [COLS-1:0] req_wdata,
    output logic            wr_done,
    output logic            rsp_valid,
    output logic [COLS-1:0] rsp_rdata,
    output logic            rsp_timeout,
    output logic            serial_in,
    output logic            shift,
    output logic            w_en,
    output logic            r_en,
    output logic [AW-1:0]   addr,
    input  logic            data_valid,
    input  logic [COLS-1:0] data_out
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        COMMIT,
        READ,
        WAIT
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [TW-1:0]   tmo_cnt_reg, tmo_cnt_next;
    logic [COLS-1:0] wdata_reg, wdata_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [COLS-1:0] rdata_reg, rdata_next;
    logic            req_ready_reg, req_ready_next;
    logic            shift_reg, shift_next;
    logic            serial_reg, serial_next;
    logic            w_en_reg, w_en_next;
    logic            wr_done_reg, wr_done_next;
    logic            r_en_reg, r_en_next;
    logic            rsp_valid_reg, rsp_valid_next;
    logic            rsp_timeout_reg, rsp_timeout_next;
    logic            accept;

    // req_ready is only ever set while sitting in IDLE, so it alone qualifies the handshake.
    assign accept = req_valid && req_ready_reg;

    always_comb begin
        state_next       = state_reg;
        bit_cnt_next     = bit_cnt_reg;
        tmo_cnt_next     = tmo_cnt_reg;
        wdata_next       = wdata_reg;
        addr_next        = addr_reg;
        rdata_next       = rdata_reg;
        req_ready_next   = 1'b0;
        shift_next       = 1'b0;
        serial_next      = 1'b0;
        w_en_next        = 1'b0;
        wr_done_next     = 1'b0;
        r_en_next        = 1'b0;
        rsp_valid_next   = 1'b0;
        rsp_timeout_next = 1'b0;

        case (state_reg)
            IDLE: begin
                req_ready_next = 1'b1;
                if (accept) begin
                    req_ready_next = 1'b0;
                    addr_next      = req_addr;
                    if (req_write) begin
                        wdata_next   = req_wdata;
                        bit_cnt_next = '0;
                        state_next   = SHIFT;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            SHIFT: begin
                // Strobes are registered from the current state, so the SRAM sees them one cycle later.
                shift_next  = 1'b1;
                serial_next = wdata_reg[COLS-1];
                wdata_next  = wdata_reg << 1;
                if (bit_cnt_reg == CW'(COLS - 1)) begin
                    state_next = COMMIT;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            COMMIT: begin
                w_en_next    = 1'b1;
                wr_done_next = 1'b1;
                state_next   = IDLE;
            end
            READ: begin
                r_en_next    = 1'b1;
                tmo_cnt_next = '0;
                state_next   = WAIT;
            end
            WAIT: begin
                // Data is checked before the timeout so a coinciding data_valid wins.
                if (data_valid) begin
                    rdata_next     = data_out;
                    rsp_valid_next = 1'b1;
                    state_next     = IDLE;
                end else if (tmo_cnt_reg == TW'(TIMEOUT - 1)) begin
                    rdata_next       = '0;
                    rsp_valid_next   = 1'b1;
                    rsp_timeout_next = 1'b1;
                    state_next       = IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= '0;
            tmo_cnt_reg     <= '0;
            wdata_reg       <= '0;
            addr_reg        <= '0;
            rdata_reg       <= '0;
            req_ready_reg   <= 1'b1;
            shift_reg       <= 1'b0;
            serial_reg      <= 1'b0;
            w_en_reg        <= 1'b0;
            wr_done_reg     <= 1'b0;
            r_en_reg        <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            tmo_cnt_reg     <= tmo_cnt_next;
            wdata_reg       <= wdata_next;
            addr_reg        <= addr_next;
            rdata_reg       <= rdata_next;
            req_ready_reg   <= req_ready_next;
            shift_reg       <= shift_next;
            serial_reg      <= serial_next;
            w_en_reg        <= w_en_next;
            wr_done_reg     <= wr_done_next;
            r_en_reg        <= r_en_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    assign req_ready   = req_ready_reg;
    assign wr_done     = wr_done_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rdata_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign serial_in   = serial_reg;
    assign shift       = shift_reg;
    assign w_en        = w_en_reg;
    assign r_en        = r_en_reg;
    assign addr        = addr_reg;

endmodule

// File: tb/tb_sram_serial_host.sv
// Directed bench for sram_serial_host with a behavioural serial-write SRAM macro
// that answers reads three cycles after r_en.
module tb_sram_serial_host;

    logic       clk;
    logic       arst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       wr_done;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_timeout;
    logic       serial_in;
    logic       shift;
    logic       w_en;
    logic       r_en;
    logic [3:0] addr;
    logic       data_valid;
    logic [7:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    sram_serial_host #(.ROWS(16), .COLS(8), .TIMEOUT(16)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .wr_done    (wr_done),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .serial_in  (serial_in),
        .shift      (shift),
        .w_en       (w_en),
        .r_en       (r_en),
        .addr       (addr),
        .data_valid (data_valid),
        .data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro model
    logic [7:0] mem [16];
    logic [7:0] sr;
    logic [2:0] rd_pipe;
    logic [3:0] rd_addr;
    logic       model_en;
    logic       stray_dv;
    logic [7:0] stray_data;

    always @(posedge clk) begin
        if (shift) sr <= {sr[6:0], serial_in};
        if (w_en) mem[addr] <= sr;
        rd_pipe <= {rd_pipe[1:0], r_en & model_en};
        if (r_en) rd_addr <= addr;
    end

    assign data_valid = rd_pipe[2] | stray_dv;
    assign data_out   = rd_pipe[2] ? mem[rd_addr] : stray_data;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    // Called at a negedge; returns at the negedge of cycle 0 (just after the handshake edge).
    task automatic issue(input logic wr, input logic [3:0] a, input logic [7:0] d);
        wait_ready();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 8'h00;
    endtask

    task automatic wait_rsp(output int cyc, output logic [7:0] rd, output logic tmo,
                            output int ren_cnt, output logic [3:0] ren_addr);
        cyc = -1; rd = 8'h00; tmo = 1'b0; ren_cnt = 0; ren_addr = 4'h0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (r_en) begin
                ren_cnt++;
                ren_addr = addr;
            end
            if (rsp_valid) begin
                cyc = c;
                rd  = rsp_rdata;
                tmo = rsp_timeout;
                break;
            end
        end
    endtask

    task automatic wait_done(output int cyc, output logic [3:0] wa);
        cyc = -1; wa = 4'h0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (wr_done) begin
                cyc = c;
                wa  = addr;
                break;
            end
        end
    endtask

    initial begin
        int         cyc;
        int         ren_cnt;
        int         wen_cnt;
        logic [7:0] rd;
        logic       tmo;
        logic [3:0] ra;
        logic [7:0] exp_bits;

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        sr = 8'h00; rd_pipe = 3'b000; rd_addr = 4'h0;
        model_en = 1'b1; stray_dv = 1'b0; stray_data = 8'h00;
        arst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0; req_wdata = 8'h00;

        // Reset
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_shift", {31'd0, shift}, 32'd0);
        chk("rst_w_en", {31'd0, w_en}, 32'd0);
        chk("rst_r_en", {31'd0, r_en}, 32'd0);
        chk("rst_wr_done", {31'd0, wr_done}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_addr", {28'd0, addr}, 32'd0);
        chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        $display("reset released: ready=%0b addr=%0d", req_ready, addr);

        // Single write: addr 5, data A5 -> serial 1,0,1,0,0,1,0,1
        exp_bits = 8'hA5;
        issue(1'b1, 4'd5, 8'hA5);
        chk("wr_c0_ready", {31'd0, req_ready}, 32'd0);
        chk("wr_c0_shift", {31'd0, shift}, 32'd0);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            chk("wr_shift", {31'd0, shift}, 32'd1);
            chk("wr_serial", {31'd0, serial_in}, {31'd0, exp_bits[8-n]});
            chk("wr_no_w_en", {31'd0, w_en}, 32'd0);
        end
        @(negedge clk);
        chk("wr_c9_w_en", {31'd0, w_en}, 32'd1);
        chk("wr_c9_done", {31'd0, wr_done}, 32'd1);
        chk("wr_c9_addr", {28'd0, addr}, 32'd5);
        chk("wr_c9_shift", {31'd0, shift}, 32'd0);
        chk("wr_c9_serial", {31'd0, serial_in}, 32'd0);
        chk("wr_c9_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("wr_c10_ready", {31'd0, req_ready}, 32'd1);
        chk("wr_c10_w_en", {31'd0, w_en}, 32'd0);
        $display("write addr=5 data=a5 committed");

        // Read back addr 5: r_en at cycle 1, data_valid at 4, response at 5
        issue(1'b0, 4'd5, 8'h00);
        chk("rd_c0_r_en", {31'd0, r_en}, 32'd0);
        wait_rsp(cyc, rd, tmo, ren_cnt, ra);
        chk("rd_rsp_cycle", cyc, 32'd5);
        chk("rd_r_en_count", ren_cnt, 32'd1);
        chk("rd_r_en_addr", {28'd0, ra}, 32'd5);
        chk("rd_rdata", {24'd0, rd}, 32'hA5);
        chk("rd_timeout", {31'd0, tmo}, 32'd0);
        $display("read addr=5 rdata=%0h timeout=%0b cycle=%0d", rd, tmo, cyc);

        // Stray data_valid while idle must be ignored
        stray_dv = 1'b1; stray_data = 8'h11;
        @(negedge clk);
        chk("rd_pulse_len", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        stray_dv = 1'b0;
        @(negedge clk);
        chk("stray_rdata", {24'd0, rsp_rdata}, 32'hA5);
        chk("stray_rsp", {31'd0, rsp_valid}, 32'd0);
        $display("stray data_valid in idle: rdata=%0h", rsp_rdata);

        // Timeout: addr 3, no data_valid -> response 16 cycles after r_en (cycle 17)
        model_en = 1'b0;
        issue(1'b0, 4'd3, 8'h00);
        wait_rsp(cyc, rd, tmo, ren_cnt, ra);
        chk("tmo_cycle", cyc, 32'd17);
        chk("tmo_flag", {31'd0, tmo}, 32'd1);
        chk("tmo_rdata", {24'd0, rd}, 32'd0);
        chk("tmo_r_en_addr", {28'd0, ra}, 32'd3);
        $display("read addr=3 timeout=%0b rdata=%0h cycle=%0d", tmo, rd, cyc);

        // data_valid on the final timeout cycle: data wins
        issue(1'b0, 4'd2, 8'h00);
        cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            stray_dv   = (c == 16);
            stray_data = 8'h5A;
            if (rsp_valid) begin
                cyc = c;
                rd  = rsp_rdata;
                tmo = rsp_timeout;
                break;
            end
        end
        stray_dv = 1'b0;
        chk("edge_cycle", cyc, 32'd17);
        chk("edge_timeout", {31'd0, tmo}, 32'd0);
        chk("edge_rdata", {24'd0, rd}, 32'h5A);
        $display("read addr=2 data on last wait cycle: rdata=%0h timeout=%0b", rd, tmo);
        model_en = 1'b1;

        // Full sweep
        for (int k = 0; k < 16; k++) begin
            issue(1'b1, 4'(k), ~8'(k));
            wait_done(cyc, ra);
            chk("sweep_wr_cycle", cyc, 32'd9);
            chk("sweep_wr_addr", {28'd0, ra}, k);
            $display("sweep write addr=%0d data=%0h done_cycle=%0d", k, ~8'(k), cyc);
        end
        for (int k = 0; k < 16; k++) begin
            issue(1'b0, 4'(k), 8'h00);
            wait_rsp(cyc, rd, tmo, ren_cnt, ra);
            chk("sweep_rd_rdata", {24'd0, rd}, {24'd0, ~8'(k)});
            chk("sweep_rd_timeout", {31'd0, tmo}, 32'd0);
            chk("sweep_rd_cycle", cyc, 32'd5);
            $display("sweep read addr=%0d rdata=%0h timeout=%0b", k, rd, tmo);
        end

        // Reset during the 4th shift cycle of a write to addr 6
        issue(1'b1, 4'd6, 8'h3C);
        for (int c = 1; c <= 4; c++) @(negedge clk);
        chk("mid_shift_active", {31'd0, shift}, 32'd1);
        arst_n = 1'b0;
        wen_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 2) arst_n = 1'b1;
            if (w_en || wr_done || rsp_valid) wen_cnt++;
            @(negedge clk);
        end
        chk("mid_no_commit", wen_cnt, 32'd0);
        chk("mid_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rdata_clr", {24'd0, rsp_rdata}, 32'd0);
        chk("mid_shift_idle", {31'd0, shift}, 32'd0);
        issue(1'b0, 4'd6, 8'h00);
        wait_rsp(cyc, rd, tmo, ren_cnt, ra);
        chk("mid_rd_rdata", {24'd0, rd}, 32'hF9);
        chk("mid_rd_timeout", {31'd0, tmo}, 32'd0);
        $display("after mid-shift reset read addr=6 rdata=%0h", rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
